// File: rtl/left_shift_pipe.sv
// left_shift_pipe: 32-bit logical left shifter as a 5-stage log-shifter pipeline.
// Stage k shifts by 2^k, accumulates a sticky lost-bit flag, and the whole pipe stalls globally.

module lsp_stage #(
  parameter int K = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  input  logic        prv_vld,
  input  logic [31:0] prv_data,
  input  logic        prv_lost,
  input  logic        shift_en,
  output logic        vld,
  output logic [31:0] data,
  output logic        lost
);
  localparam int DIST = 1 << K;

  logic [31:0] nxt_data;
  logic        nxt_lost;

  always_comb begin
    nxt_data = prv_data;
    nxt_lost = prv_lost;
    if (shift_en) begin
      nxt_data = prv_data << DIST;
      nxt_lost = prv_lost | (|prv_data[31 -: DIST]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld  <= 1'b0;
      data <= '0;
      lost <= 1'b0;
    end else if (advance) begin
      vld  <= prv_vld;
      data <= nxt_data;
      lost <= nxt_lost;
    end
  end
endmodule

module left_shift_pipe (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in,
  input  logic [4:0]  shiftamount,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_lost,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int STAGES = 5;
  localparam int SH_W   = 5;

  // Stage k keeps only the shift bits still to be applied (STAGES-1-k of them),
  // packed back to back; its lowest kept bit drives the next stage.
  function automatic int rem_off(input int k);
    return (STAGES - 1) * k - (k * (k - 1)) / 2;
  endfunction

  localparam int REM_BITS = rem_off(STAGES - 1);

  logic                    advance;
  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0][31:0]   data_pipe;
  logic [STAGES:0]         lost_pipe;
  logic [STAGES-1:0]       shift_en;
  logic [REM_BITS-1:0]     rem;

  assign advance      = !out_valid || out_ready;
  assign in_ready     = advance;
  assign vld_pipe[0]  = in_valid;
  assign data_pipe[0] = in;
  assign lost_pipe[0] = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign shift_en[k] = shiftamount[0];
    end else begin : g_next
      assign shift_en[k] = rem[rem_off(k - 1)];
    end

    if (k < STAGES - 1) begin : g_rem
      localparam int W = STAGES - 1 - k;
      logic [W-1:0] rem_d;

      if (k == 0) begin : g_src_in
        assign rem_d = shiftamount[SH_W-1:1];
      end else begin : g_src_prv
        assign rem_d = rem[rem_off(k - 1) + 1 +: W];
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset)       rem[rem_off(k) +: W] <= '0;
        else if (advance) rem[rem_off(k) +: W] <= rem_d;
      end
    end

    lsp_stage #(.K(k)) u_stage (
      .clock    (clock),
      .reset    (reset),
      .advance  (advance),
      .prv_vld  (vld_pipe[k]),
      .prv_data (data_pipe[k]),
      .prv_lost (lost_pipe[k]),
      .shift_en (shift_en[k]),
      .vld      (vld_pipe[k+1]),
      .data     (data_pipe[k+1]),
      .lost     (lost_pipe[k+1])
    );
  end

  assign out       = data_pipe[STAGES];
  assign out_lost  = lost_pipe[STAGES];
  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_left_shift_pipe.sv
// Directed + random checks of left_shift_pipe against hand values and a 64-bit shift model.
`timescale 1ns/1ps
module tb_left_shift_pipe;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in;
  logic [4:0]  shiftamount;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out;
  logic        out_lost;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] exp_q[$];
  logic        got_valid;
  logic        got_ready;
  logic [31:0] got_out;

  left_shift_pipe dut (
    .clock       (clock),
    .reset       (reset),
    .in          (in),
    .shiftamount (shiftamount),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out         (out),
    .out_lost    (out_lost),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_shift(input logic [31:0] d, input logic [4:0] s);
    logic [63:0] w;
    w = {32'd0, d} << s;
    return {|w[63:32], w[31:0]};
  endfunction

  // One clock cycle: drive after negedge, evaluate handshakes before the next posedge.
  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] s,
                      input logic ordy, input logic [31:0] e_out, input logic e_lost);
    logic [32:0] e;
    @(negedge clock);
    in_valid = v; in = d; shiftamount = s; out_ready = ordy;
    #1;
    got_valid = out_valid;
    got_ready = in_ready;
    got_out   = out;
    chk("in_ready", 32'(in_ready), 32'(!out_valid || ordy));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious", 32'(1), 32'(0));
      else begin
        e = exp_q.pop_front();
        chk("out", out, e[31:0]);
        chk("lost", 32'(out_lost), 32'(e[32]));
      end
    end
    if (v && in_ready && reset) exp_q.push_back({e_lost, e_out});
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 5'd0, 1'b1, 32'd0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] e;
    logic [31:0] fill_d [5];
    logic [4:0]  fill_s [5];
    logic        fill_l [5];
    fill_d = '{32'h0000014A, 32'h00000528, 32'h0000A500, 32'h00A50000, 32'h50000000};
    fill_s = '{5'd1, 5'd3, 5'd8, 5'd16, 5'd28};
    fill_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with a valid operand presented: must not be accepted.
    reset = 1'b0; in_valid = 1'b1; in = 32'hFFFF_FFFF; shiftamount = 5'd3; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_vld", 32'(out_valid), 32'(0));
    chk("rst_out", out, 32'd0);
    chk("rst_lost", 32'(out_lost), 32'(0));
    chk("rst_rdy", 32'(in_ready), 32'(1));
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle();
      chk("rst_noaccept", 32'(got_valid), 32'(0));
    end

    // Latency: 1 << 31 appears exactly five cycles later.
    step(1'b1, 32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("lat_wait", 32'(got_valid), 32'(0));
    end
    idle();
    chk("lat_hit", 32'(got_valid), 32'(1));

    // Lost bit on, and shift of zero passes through.
    step(1'b1, 32'hF000_0001, 5'd4, 1'b1, 32'h0000_0010, 1'b1);
    step(1'b1, 32'hF000_0001, 5'd0, 1'b1, 32'hF000_0001, 1'b0);
    repeat (6) idle();

    // Back-to-back stream of ten: ten consecutive valid cycles.
    for (int i = 0; i < 15; i++) begin
      if (i < 10) step(1'b1, 32'hFFFF_FFFF, 5'(i), 1'b1, 32'hFFFF_FFFF << i, i != 0);
      else idle();
      chk("b2b_vld", 32'(got_valid), 32'(i >= 5));
    end
    chk("b2b_drain", 32'(exp_q.size()), 32'(0));

    // Fill, then stall seven cycles with an operand waiting at the input.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0000_00A5, fill_s[i], 1'b1, fill_d[i], fill_l[i]);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 32'hDEAD_BEEF, 5'd2, 1'b0, 32'h7AB6_FBBC, 1'b1);
      chk("stall_rdy", 32'(got_ready), 32'(0));
      chk("stall_vld", 32'(got_valid), 32'(1));
      chk("stall_out", got_out, 32'h0000_014A);
    end
    repeat (6) idle();
    chk("stall_drain", 32'(exp_q.size()), 32'(0));

    // Reset with operands in flight: output clears at once, nothing stale afterwards.
    for (int i = 0; i < 6; i++) begin
      e = ref_shift(32'(i + 1), 5'(i));
      step(1'b1, 32'(i + 1), 5'(i), 1'b1, e[31:0], e[32]);
    end
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'(0));
    chk("mid_rst_rdy", 32'(in_ready), 32'(1));
    chk("mid_rst_out", out, 32'd0);
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle();
      chk("post_rst_idle", 32'(got_valid), 32'(0));
    end
    step(1'b1, 32'h0000_0003, 5'd2, 1'b1, 32'h0000_000C, 1'b0);
    repeat (4) idle();
    idle();
    chk("post_rst_lat", 32'(got_valid), 32'(1));

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] d;
      logic [4:0]  s;
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      e = ref_shift(d, s);
      step(($urandom % 4) != 0, d, s, ($urandom % 4) != 0, e[31:0], e[32]);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
    chk("final_drain", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
